// File: rtl/onehot_decoder_pipe.sv
// Registered binary-to-one-hot decoder with a 2-entry skid buffer
// and a sticky accumulator of every delivered one-hot word.
module onehot_decoder_pipe #(
  parameter int CODE_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CODE_WIDTH-1:0]        in_code,
  input  logic                         in_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(1<<CODE_WIDTH)-1:0]   out_onehot,
  output logic [(1<<CODE_WIDTH)-1:0]   seen,
  input  logic                         seen_clr
);

  localparam int DEC_WIDTH = 1 << CODE_WIDTH;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [DEC_WIDTH-1:0] head;
  logic [DEC_WIDTH-1:0] tail;
  logic [DEC_WIDTH-1:0] word;
  logic                 push;
  logic                 pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    word = '0;
    if (in_en)
      word = {{(DEC_WIDTH-1){1'b0}}, 1'b1} << in_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= EMPTY;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      EMPTY: if (push) state_nx = ONE;
      ONE: begin
        if (push && !pop)
          state_nx = FULL;
        else if (pop && !push)
          state_nx = EMPTY;
      end
      FULL: if (pop) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    unique case (state)
      EMPTY: ;
      ONE:   out_valid = 1'b1;
      FULL: begin
        out_valid = 1'b1;
        in_ready  = 1'b0;
      end
      default: ;
    endcase
  end

  assign out_onehot = out_valid ? head : '0;

  // head is the oldest word; tail only fills while head is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push && (state == EMPTY || pop))
        head <= word;
      else if (pop && state == FULL)
        head <= tail;
      if (push && state == ONE && !pop)
        tail <= word;
    end
  end

  // a word popped alongside a clear survives it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seen <= '0;
    else if (seen_clr && pop)
      seen <= out_onehot;
    else if (seen_clr)
      seen <= '0;
    else if (pop)
      seen <= seen | out_onehot;
  end

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
// Bench for onehot_decoder_pipe: directed scenarios with literal
// expectations plus randomized traffic against a queue model.
module tb_onehot_decoder_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_code = '0;
  logic       in_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_onehot;
  logic [7:0] seen;
  logic       seen_clr = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0] mq[$];
  logic [7:0] mseen = '0;
  logic       rdy_q;

  onehot_decoder_pipe #(.CODE_WIDTH(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_code(in_code),
    .in_en(in_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_onehot(out_onehot),
    .seen(seen),
    .seen_clr(seen_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO of decoded words capped at two entries.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mseen = '0;
    end else begin
      logic       p_push, p_pop;
      logic [7:0] w, hd;
      p_push = in_valid && (mq.size() < 2);
      p_pop  = (mq.size() > 0) && out_ready;
      w  = in_en ? (8'd1 << in_code) : 8'd0;
      hd = (mq.size() > 0) ? mq[0] : 8'd0;
      if (seen_clr)
        mseen = p_pop ? hd : 8'd0;
      else if (p_pop)
        mseen = mseen | hd;
      if (p_pop) void'(mq.pop_front());
      if (p_push) mq.push_back(w);
    end
  end

  always @(negedge clk) begin
    chk("m_valid", {7'd0, out_valid}, {7'd0, mq.size() > 0});
    chk("m_ready", {7'd0, in_ready}, {7'd0, mq.size() < 2});
    chk("m_onehot", out_onehot, (mq.size() > 0) ? mq[0] : 8'd0);
    chk("m_seen", seen, mseen);
  end

  task automatic cyc();
    @(negedge clk);
    rdy_q = in_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_onehot", out_onehot, 8'h00);
    chk("rst_seen", seen, 8'h00);
    chk("rst_ready", {7'd0, in_ready}, 8'd1);

    // code 5 decodes to bit 5
    in_valid = 1; in_code = 3'd5; in_en = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    chk("t1_valid", {7'd0, out_valid}, 8'd1);
    chk("t1_onehot", out_onehot, 8'h20);
    cyc();
    chk("t1_seen", seen, 8'h20);

    // backpressure: third push must be held
    out_ready = 0; in_valid = 1; in_code = 3'd1;
    cyc();
    in_code = 3'd2;
    cyc();
    in_code = 3'd3;
    chk("t2_full", {7'd0, in_ready}, 8'd0);
    cyc();
    chk("t2_hold", out_onehot, 8'h02);
    out_ready = 1;
    cyc();
    chk("t2_o1", out_onehot, 8'h04);
    cyc();
    chk("t2_o2", out_onehot, 8'h08);
    in_valid = 0;
    cyc();
    chk("t2_empty", {7'd0, out_valid}, 8'd0);
    chk("t2_seen", seen, 8'h2e);

    // disabled decode yields zero word
    out_ready = 0; in_valid = 1; in_code = 3'd7; in_en = 0;
    cyc();
    in_valid = 0; in_en = 1;
    chk("t3_valid", {7'd0, out_valid}, 8'd1);
    chk("t3_onehot", out_onehot, 8'h00);
    out_ready = 1;
    cyc();
    chk("t3_seen", seen, 8'h2e);

    // push+pop while holding one entry
    out_ready = 0; seen_clr = 1;
    cyc();
    seen_clr = 0;
    in_valid = 1; in_code = 3'd6;
    cyc();
    in_code = 3'd0; out_ready = 1;
    cyc();
    in_valid = 0; out_ready = 0;
    chk("t4_ready", {7'd0, in_ready}, 8'd1);
    chk("t4_onehot", out_onehot, 8'h01);
    chk("t4_seen", seen, 8'h40);

    // clear colliding with a pop, then clear alone
    out_ready = 1;
    cyc();
    chk("t5_seen41", seen, 8'h41);
    out_ready = 0; in_valid = 1; in_code = 3'd4;
    cyc();
    in_valid = 0; out_ready = 1; seen_clr = 1;
    cyc();
    chk("t5_clrpop", seen, 8'h10);
    out_ready = 0;
    cyc();
    seen_clr = 0;
    chk("t5_clr", seen, 8'h00);

    // async reset while full
    in_valid = 1; in_code = 3'd2;
    cyc();
    in_code = 3'd7; out_ready = 1;
    cyc();
    in_code = 3'd1; out_ready = 0;
    cyc();
    in_valid = 0;
    chk("t6_full", {7'd0, in_ready}, 8'd0);
    chk("t6_seen", seen, 8'h04);
    #1 rst_n = 0;
    #1;
    chk("t6_valid", {7'd0, out_valid}, 8'd0);
    chk("t6_onehot", out_onehot, 8'h00);
    chk("t6_rseen", seen, 8'h00);
    cyc();
    rst_n = 1;
    in_valid = 1; in_code = 3'd3;
    cyc();
    in_valid = 0;
    chk("t6_post", out_onehot, 8'h08);
    cyc();

    // randomized traffic; producer holds a refused offer
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !rdy_q)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_code  = 3'($urandom_range(0, 7));
        in_en    = ($urandom_range(0, 4) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      seen_clr  = ($urandom_range(0, 15) == 0);
      cyc();
    end
    in_valid = 0; seen_clr = 0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
